spram_bank_pwr_ctrl: RTL and testbench

// - Power-mode sequencer for the two 16K x 32 SPRAM banks behind the instruction memory (bank = addr[14]).
// - Drops idle banks into standby, then optionally sleep, using per-bank idle timers.
// - On an access, wakes the target bank and returns req_ready only when that bank is usable.
// - Sits between the fetch/load port and the bank array. Drives each bank's chip_sel, standby, sleep and poweroff.

---
 rtl/spram_bank_pwr_ctrl.sv | 134 +++++++++++++
 tb/tb_spram_bank_pwr_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spram_bank_pwr_ctrl.sv
// Power-mode sequencer for two SPRAM banks; idle banks drop to STANDBY (and SLEEP when SPRAM_SLEEP_EN is defined).
// Latency: req_ready is combinational when the bank is ACTIVE, else STBY_WAKE+1 / SLEEP_WAKE+1 cycles.
// Backpressure: req is held until req_ready; no access reaches a bank that is not ACTIVE.
module spram_bank_pwr_ctrl #(
  parameter int STBY_IDLE  = 64,
  parameter int SLEEP_IDLE = 1024,
  parameter int STBY_WAKE  = 1,
  parameter int SLEEP_WAKE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       req_bank,
  input  logic       hold_awake,
  output logic       req_ready,
  output logic [1:0] bank_chip_sel,
  output logic [1:0] bank_standby,
  output logic [1:0] bank_sleep,
  output logic [1:0] bank_poweroff,
  output logic [3:0] bank_state
);

  localparam int TW = $clog2(SLEEP_IDLE + 1);
  localparam int WMAX = (SLEEP_WAKE > STBY_WAKE) ? SLEEP_WAKE : STBY_WAKE;
  localparam int WW = $clog2(WMAX + 1);
`ifdef SPRAM_SLEEP_EN
  localparam int TSAT = SLEEP_IDLE;
  localparam logic [TW-1:0] T_SLEEP = TW'(SLEEP_IDLE - 1);
  localparam logic [WW-1:0] W_SLEEP = WW'(SLEEP_WAKE);
`else
  localparam int TSAT = STBY_IDLE;
`endif
  localparam logic [TW-1:0] T_SAT  = TW'(TSAT);
  localparam logic [TW-1:0] T_STBY = TW'(STBY_IDLE - 1);
  localparam logic [WW-1:0] W_STBY = WW'(STBY_WAKE);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_STANDBY = 2'd1,
    ST_SLEEP   = 2'd2,
    ST_WAKE    = 2'd3
  } state_t;

  state_t          state_q [2];
  state_t          state_d [2];
  logic [TW-1:0]   timer_q [2];
  logic [TW-1:0]   timer_d [2];
  logic [WW-1:0]   wcnt_q  [2];
  logic [WW-1:0]   wcnt_d  [2];
  logic [1:0]      hit;
  logic [1:0]      access;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (reset) begin
        state_q[b] <= ST_ACTIVE;
        timer_q[b] <= '0;
        wcnt_q[b]  <= '0;
      end else begin
        state_q[b] <= state_d[b];
        timer_q[b] <= timer_d[b];
        wcnt_q[b]  <= wcnt_d[b];
      end
    end
  end

  always_comb begin
    hit    = '0;
    access = '0;
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      wcnt_d[b]  = wcnt_q[b];
      timer_d[b] = timer_q[b];
      hit[b]     = req && (req_bank == 1'(b));
      access[b]  = hit[b] && (state_q[b] == ST_ACTIVE);

      if (access[b] || hold_awake || (state_q[b] == ST_WAKE))
        timer_d[b] = '0;
      else if (timer_q[b] != T_SAT)
        timer_d[b] = timer_q[b] + 1'b1;

      // A request or hold always beats an idle-timer transition in the same cycle.
      unique case (state_q[b])
        ST_ACTIVE: begin
          if (!access[b] && !hold_awake && (timer_q[b] == T_STBY))
            state_d[b] = ST_STANDBY;
        end
        ST_STANDBY: begin
          if (hit[b] || hold_awake) begin
            state_d[b] = ST_WAKE;
            wcnt_d[b]  = W_STBY;
          end
`ifdef SPRAM_SLEEP_EN
          else if (timer_q[b] == T_SLEEP)
            state_d[b] = ST_SLEEP;
`endif
        end
        ST_SLEEP: begin
          if (hit[b] || hold_awake) begin
            state_d[b] = ST_WAKE;
`ifdef SPRAM_SLEEP_EN
            wcnt_d[b]  = W_SLEEP;
`else
            wcnt_d[b]  = W_STBY;
`endif
          end
        end
        ST_WAKE: begin
          if (wcnt_q[b] <= WW'(1))
            state_d[b] = ST_ACTIVE;
          else
            wcnt_d[b] = wcnt_q[b] - 1'b1;
        end
        default: state_d[b] = ST_ACTIVE;
      endcase
    end
  end

  always_comb begin
    req_ready     = |access;
    bank_chip_sel = access;
    bank_poweroff = 2'b11;
    bank_state    = {state_q[1], state_q[0]};
    bank_standby  = '0;
    bank_sleep    = '0;
    for (int b = 0; b < 2; b++) begin
      bank_standby[b] = (state_q[b] == ST_STANDBY) || (state_q[b] == ST_SLEEP);
`ifdef SPRAM_SLEEP_EN
      bank_sleep[b]   = (state_q[b] == ST_SLEEP);
`endif
    end
  end

endmodule

// File: tb/tb_spram_bank_pwr_ctrl.sv
// Bench for spram_bank_pwr_ctrl: a per-bank model (idle count + remaining wake cycles)
// predicts every cycle's outputs; a negedge monitor pops and compares them.
module tb_spram_bank_pwr_ctrl;

  localparam int STBY_IDLE  = 4;
  localparam int SLEEP_IDLE = 10;
  localparam int STBY_WAKE  = 1;
  localparam int SLEEP_WAKE = 4;
`ifdef SPRAM_SLEEP_EN
  localparam bit SLEEP_ON = 1'b1;
`else
  localparam bit SLEEP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       req_bank = 1'b0;
  logic       hold_awake = 1'b0;
  logic       req_ready;
  logic [1:0] bank_chip_sel;
  logic [1:0] bank_standby;
  logic [1:0] bank_sleep;
  logic [1:0] bank_poweroff;
  logic [3:0] bank_state;

  spram_bank_pwr_ctrl #(
    .STBY_IDLE (STBY_IDLE),
    .SLEEP_IDLE(SLEEP_IDLE),
    .STBY_WAKE (STBY_WAKE),
    .SLEEP_WAKE(SLEEP_WAKE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_bank     (req_bank),
    .hold_awake   (hold_awake),
    .req_ready    (req_ready),
    .bank_chip_sel(bank_chip_sel),
    .bank_standby (bank_standby),
    .bank_sleep   (bank_sleep),
    .bank_poweroff(bank_poweroff),
    .bank_state   (bank_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic [1:0] cs;
    logic [1:0] stby;
    logic [1:0] slp;
    logic [1:0] poff;
    logic [3:0] st;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e;
  obs_t mon_a;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: cycles since the bank was last accessed/held/woken, and WAKE cycles still to run.
  int idle[2];
  int wake_left[2];

  function automatic int mstate(input int b);
    if (wake_left[b] > 0) return 3;
    if (SLEEP_ON && idle[b] >= SLEEP_IDLE) return 2;
    if (idle[b] >= STBY_IDLE) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      idle[b]      = 0;
      wake_left[b] = 0;
    end
  endtask

  task automatic cycle(input bit r, input bit bk, input bit h, input bit rst, output bit rdy);
    obs_t e;
    int   st[2];
    req        = r;
    req_bank   = bk;
    hold_awake = h;
    reset      = rst;
    for (int b = 0; b < 2; b++) st[b] = mstate(b);
    e = '0;
    e.rdy  = r && (st[bk] == 0);
    e.poff = 2'b11;
    e.st   = {2'(st[1]), 2'(st[0])};
    for (int b = 0; b < 2; b++) begin
      e.cs[b]   = r && (int'(bk) == b) && (st[b] == 0);
      e.stby[b] = (st[b] == 1) || (st[b] == 2);
      e.slp[b]  = (st[b] == 2);
    end
    exp_q.push_back(e);
    rdy = e.rdy;
    if (rst) begin
      model_reset();
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wake_left[b] > 0) begin
          wake_left[b]--;
          idle[b] = 0;
        end else if (st[b] != 0 && ((r && int'(bk) == b) || h)) begin
          wake_left[b] = (st[b] == 2) ? SLEEP_WAKE : STBY_WAKE;
          idle[b]      = 0;
        end else if (e.cs[b] || h) begin
          idle[b] = 0;
        end else begin
          idle[b]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input bit h);
    bit rdy;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, h, 1'b0, rdy);
  endtask

  // Holds req until the model grants it; optionally retargets the other bank after switch_after cycles.
  task automatic request(input bit bk, input int switch_after, input bit h);
    bit rdy;
    bit tgt;
    int n;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 64) begin
      tgt = (switch_after > 0 && n >= switch_after) ? ~bk : bk;
      cycle(1'b1, tgt, h, 1'b0, rdy);
      n++;
    end
    req = 1'b0;
    n_cmp++;
    if (!rdy) begin
      n_bad++;
      $display("FAIL wait t=%0t: request to bank %0d not granted within %0d cycles", $time, bk, n);
    end
  endtask

  task automatic check_reset_state();
    n_cmp++;
    if (req_ready !== 1'b0 || bank_chip_sel !== 2'b00 || bank_standby !== 2'b00 ||
        bank_sleep !== 2'b00 || bank_poweroff !== 2'b11 || bank_state !== 4'h0) begin
      n_bad++;
      $display("FAIL reset t=%0t: got rdy=%b cs=%b stby=%b slp=%b poff=%b st=%h",
               $time, req_ready, bank_chip_sel, bank_standby, bank_sleep, bank_poweroff, bank_state);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {req_ready, bank_chip_sel, bank_standby, bank_sleep, bank_poweroff, bank_state};
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL outputs t=%0t: got rdy=%b cs=%b stby=%b slp=%b poff=%b st=%h, need rdy=%b cs=%b stby=%b slp=%b poff=%b st=%h",
                 $time, mon_a.rdy, mon_a.cs, mon_a.stby, mon_a.slp, mon_a.poff, mon_a.st,
                 mon_e.rdy, mon_e.cs, mon_e.stby, mon_e.slp, mon_e.poff, mon_e.st);
      end
    end
  end

  initial begin
    bit rdy;
    int gap;
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();

    // Directed scenarios
    request(1'b0, 0, 1'b0);
    idle_cycles(6, 1'b0);
    request(1'b1, 0, 1'b0);
    idle_cycles(12, 1'b0);
    request(1'b0, 0, 1'b0);
    idle_cycles(12, 1'b0);
    request(1'b0, 2, 1'b0);
    idle_cycles(6, 1'b0);
    request(1'b0, 0, 1'b0);
    idle_cycles(STBY_IDLE - 1, 1'b0);
    request(1'b0, 0, 1'b0);
    idle_cycles(2, 1'b0);
    idle_cycles(12, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, rdy);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, rdy);
    idle_cycles(3, 1'b0);
    idle_cycles(12, 1'b0);
    idle_cycles(8, 1'b1);
    idle_cycles(6, 1'b0);

    // Randomized traffic
    repeat (400) begin
      case ($urandom_range(0, 49))
        0: cycle(1'b0, 1'b0, 1'b0, 1'b1, rdy);
        1, 2, 3, 4, 5: idle_cycles($urandom_range(1, 6), 1'b1);
        default: ;
      endcase
      case ($urandom_range(0, 2))
        0: gap = $urandom_range(0, 3);
        1: gap = $urandom_range(3, 6);
        default: gap = $urandom_range(8, 14);
      endcase
      idle_cycles(gap, 1'b0);
      request(1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0,
              ($urandom_range(0, 9) == 0));
    end

    req        = 1'b0;
    hold_awake = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
